// File: rtl/seq_right_shifter.sv
// Iterative right shifter: loads a word and a shift amount on Start, then
// shifts right one bit per clock (logical or arithmetic) until the amount is
// consumed, and pulses Done for one cycle when Out holds the result.
//
// Handshake: Start is a request that is taken only on an edge where the FSM
// is in IDLE or DONE. Start is ignored while Busy is high, so the requester
// must hold or re-issue Start if it must not be lost. Done is a one-cycle
// pulse with no acknowledge. Out holds its value until the next accepted
// Start or reset.
//
// The FSM state is fully visible on the ports: Busy decodes SHIFT, Done
// decodes DONE, and both low means IDLE.
module seq_right_shifter #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [N-1:0]  In,
  input  logic [SW-1:0] Amount,
  input  logic          Arith,
  output logic [N-1:0]  Out,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  out_q, out_d;
  logic [SW-1:0] count_q, count_d;
  logic          mode_q, mode_d;
  logic          fill;

  // Fill bit entering at the MSB: the current sign bit in arithmetic mode.
  always_comb begin
    fill = mode_q ? out_q[N-1] : 1'b0;
  end

  // Next-state and datapath: load on an accepted Start, shift while in SHIFT.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    count_d = count_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          out_d   = In;
          count_d = Amount;
          mode_d  = Arith;
          state_d = (Amount == '0) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        out_d   = {fill, out_q[N-1:1]};
        count_d = count_q - SW'(1);
        if (count_q == SW'(1)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any shift in progress.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  // Status outputs decode registered state, so they never glitch or overlap.
  always_comb begin
    Out  = out_q;
    Busy = (state_q == S_SHIFT);
    Done = (state_q == S_DONE);
  end

endmodule
